// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer.
// Optional feature macro: BTB_BHT_EN (adds a 2-bit direction counter per entry).
package btb_pkg;

   localparam int PC_W      = 32;
   localparam int TAG_MAX_W = 30;

   // 2-bit direction counter encodings.
   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } ctr_e;

   // One table entry. The tag field is sized for the smallest legal index
   // width; tags are stored zero-extended so comparisons use the full field.
   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
      logic [PC_W-1:0]      target;
`ifdef BTB_BHT_EN
      ctr_e                 ctr;
`endif
   } btb_entry_t;

   // Number of meaningful tag bits for a given index width.
   function automatic int tag_width(input int idx_w);
      return PC_W - 2 - idx_w;
   endfunction

   // Tag of a PC: everything above the index and the byte offset.
   function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [PC_W-1:0] pc,
                                                   input int idx_w);
      logic [PC_W-1:0] shifted;
      shifted = pc >> (idx_w + 2);
      return shifted[TAG_MAX_W-1:0];
   endfunction

   // Saturating increment of the direction counter.
   function automatic ctr_e ctr_inc(input ctr_e c);
      return (c == ST) ? ST : ctr_e'(c + 2'd1);
   endfunction

   // Saturating decrement of the direction counter.
   function automatic ctr_e ctr_dec(input ctr_e c);
      return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
   endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping.
module btb_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = W'(1);
   localparam logic [W-1:0] MAX = {W{1'b1}};

   // Count events, holding once the maximum is reached.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != MAX)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with EX-stage resolution.
// IF side: zero-latency lookup of PCF. EX side: misprediction detection,
// redirect PC, table update and statistics counters.
// Optional feature macro: BTB_BHT_EN (per-entry 2-bit direction counter).
module btb_predictor
   import btb_pkg::*;
#(
   parameter int IDX_W = 6,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      PCF,
   output logic [31:0]      PPCF,
   output logic             BTBF,
   input  logic [31:0]      PCE,
   input  logic [31:0]      PPCE,
   input  logic             BTBE,
   input  logic             BrValidE,
   input  logic             BrTakenE,
   input  logic [31:0]      BrTargetE,
   input  logic             StallE,
   output logic             MispredE,
   output logic [31:0]      CorrectPCE,
   output logic [CNT_W-1:0] BranchCnt,
   output logic [CNT_W-1:0] MispredCnt
);

   localparam int DEPTH = 2 ** IDX_W;

   btb_entry_t btb_q [DEPTH];

   logic [IDX_W-1:0]     idx_f;
   logic [IDX_W-1:0]     idx_e;
   logic [TAG_MAX_W-1:0] tag_f;
   logic [TAG_MAX_W-1:0] tag_e;
   btb_entry_t           entry_f;
   btb_entry_t           entry_e;
   logic                 hit_f;
   logic                 hit_e;
   logic [31:0]          pcf_plus4;
   logic [31:0]          pce_plus4;
   logic [31:0]          actual_npc;
   logic [31:0]          pred_npc;
   logic                 upd_en;
   logic                 alias_inv;
   logic                 br_count;

   // Fetch-side lookup; reads the registered table, so a same-cycle write
   // becomes visible only on the following cycle.
   always_comb begin
      idx_f     = PCF[IDX_W+1:2];
      tag_f     = tag_of(PCF, IDX_W);
      entry_f   = btb_q[idx_f];
      hit_f     = entry_f.valid && (entry_f.tag == tag_f);
      pcf_plus4 = PCF + 32'd4;
`ifdef BTB_BHT_EN
      BTBF      = hit_f && entry_f.ctr[1];
`else
      BTBF      = hit_f;
`endif
      PPCF      = BTBF ? entry_f.target : pcf_plus4;
   end

   // EX-side resolution: compare what actually happens with what fetch
   // assumed, and pick the PC to restart from.
   always_comb begin
      idx_e      = PCE[IDX_W+1:2];
      tag_e      = tag_of(PCE, IDX_W);
      entry_e    = btb_q[idx_e];
      hit_e      = entry_e.valid && (entry_e.tag == tag_e);
      pce_plus4  = PCE + 32'd4;
      actual_npc = BrTakenE ? BrTargetE : pce_plus4;
      pred_npc   = BTBE ? PPCE : pce_plus4;
      MispredE   = !StallE && ((BrValidE && (actual_npc != pred_npc)) ||
                               (!BrValidE && BTBE));
      CorrectPCE = BrValidE ? actual_npc : pce_plus4;
      upd_en     = !StallE && BrValidE;
      // A non-branch that fetch predicted taken hit an aliased entry.
      alias_inv  = !StallE && !BrValidE && BTBE;
      br_count   = !StallE && BrValidE;
   end

   // Table maintenance; reset clears every entry and drops any pending update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            btb_q[i].valid <= 1'b0;
`ifdef BTB_BHT_EN
            btb_q[i].ctr   <= SNT;
`endif
         end
      end else if (upd_en) begin
         if (BrTakenE) begin
`ifdef BTB_BHT_EN
            if (hit_e) begin
               btb_q[idx_e].ctr <= ctr_inc(entry_e.ctr);
            end else begin
               btb_q[idx_e].ctr <= WT;
            end
`endif
            // Taken: allocate or replace, always refreshing the target.
            btb_q[idx_e].valid  <= 1'b1;
            btb_q[idx_e].tag    <= tag_e;
            btb_q[idx_e].target <= BrTargetE;
         end else if (hit_e) begin
`ifdef BTB_BHT_EN
            btb_q[idx_e].ctr   <= ctr_dec(entry_e.ctr);
`else
            btb_q[idx_e].valid <= 1'b0;
`endif
         end
      end else if (alias_inv) begin
         btb_q[idx_e].valid <= 1'b0;
      end
   end

   btb_sat_counter #(.W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (br_count),
      .count (BranchCnt)
   );

   btb_sat_counter #(.W(CNT_W)) u_mispred_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (MispredE),
      .count (MispredCnt)
   );

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor. Counters are built 3 bits wide so that
// saturation is reachable in a short run.
module tb_btb_predictor;

   localparam int IDX_W = 6;
   localparam int CNT_W = 3;

   logic             clk;
   logic             rst;
   logic [31:0]      PCF;
   logic [31:0]      PPCF;
   logic             BTBF;
   logic [31:0]      PCE;
   logic [31:0]      PPCE;
   logic             BTBE;
   logic             BrValidE;
   logic             BrTakenE;
   logic [31:0]      BrTargetE;
   logic             StallE;
   logic             MispredE;
   logic [31:0]      CorrectPCE;
   logic [CNT_W-1:0] BranchCnt;
   logic [CNT_W-1:0] MispredCnt;

   int n_total;
   int n_bad;

   btb_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .PCF        (PCF),
      .PPCF       (PPCF),
      .BTBF       (BTBF),
      .PCE        (PCE),
      .PPCE       (PPCE),
      .BTBE       (BTBE),
      .BrValidE   (BrValidE),
      .BrTakenE   (BrTakenE),
      .BrTargetE  (BrTargetE),
      .StallE     (StallE),
      .MispredE   (MispredE),
      .CorrectPCE (CorrectPCE),
      .BranchCnt  (BranchCnt),
      .MispredCnt (MispredCnt)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are
   // sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_idle();
      PCE       = 32'h0;
      PPCE      = 32'h4;
      BTBE      = 1'b0;
      BrValidE  = 1'b0;
      BrTakenE  = 1'b0;
      BrTargetE = 32'h0;
      StallE    = 1'b0;
   endtask

   task automatic ex_drive(input logic [31:0] pc, input logic btb,
                           input logic [31:0] ppc, input logic valid,
                           input logic taken, input logic [31:0] tgt);
      PCE       = pc;
      BTBE      = btb;
      PPCE      = ppc;
      BrValidE  = valid;
      BrTakenE  = taken;
      BrTargetE = tgt;
   endtask

   task automatic check_cnts(input string tag, input int br, input int mp);
      check_eq({tag, "_brcnt"}, 32'(BranchCnt), br);
      check_eq({tag, "_mpcnt"}, 32'(MispredCnt), mp);
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst     = 1'b1;
      PCF     = 32'h100;
      ex_idle();
      tick();
      tick();
      rst = 1'b0;
      #1;

      // Reset state.
      check_eq("rst_btbf", 32'(BTBF), 0);
      check_eq("rst_ppcf", PPCF, 32'h104);
      check_cnts("rst", 0, 0);

      // Taken branch unknown to the table.
      ex_drive(32'h100, 1'b0, 32'h104, 1'b1, 1'b1, 32'h40);
      #1;
      check_eq("tk_mispred", 32'(MispredE), 1);
      check_eq("tk_cpc", CorrectPCE, 32'h40);
      check_eq("tk_old_btbf", 32'(BTBF), 0);
      tick();
      ex_idle();
      #1;
      check_eq("tk_new_btbf", 32'(BTBF), 1);
      check_eq("tk_new_ppcf", PPCF, 32'h40);
      check_cnts("tk", 1, 1);

      // Predicted taken, resolves not taken.
      ex_drive(32'h100, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0);
      #1;
      check_eq("nt_mispred", 32'(MispredE), 1);
      check_eq("nt_cpc", CorrectPCE, 32'h104);
      tick();
      ex_idle();
      #1;
      check_eq("nt_btbf", 32'(BTBF), 0);
      check_eq("nt_ppcf", PPCF, 32'h104);
      check_cnts("nt", 2, 2);

      // Re-train taken, then probe an alias with the same index.
      ex_drive(32'h100, 1'b0, 32'h104, 1'b1, 1'b1, 32'h80);
      tick();
      ex_idle();
      #1;
      check_eq("rt_btbf", 32'(BTBF), 1);
      check_eq("rt_ppcf", PPCF, 32'h80);
      PCF = 32'h100 + (32'd4 << IDX_W);
      #1;
      check_eq("alias_btbf", 32'(BTBF), 0);
      check_eq("alias_ppcf", PPCF, 32'h204);
      check_cnts("rt", 3, 3);

      // Non-branch at the aliasing PC that fetch predicted taken.
      ex_drive(32'h200, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
      #1;
      check_eq("nb_mispred", 32'(MispredE), 1);
      check_eq("nb_cpc", CorrectPCE, 32'h204);
      tick();
      ex_idle();
      PCF = 32'h100;
      #1;
      check_eq("nb_cleared", 32'(BTBF), 0);
      check_cnts("nb", 3, 4);

      // Correctly predicted not-taken branch.
      ex_drive(32'h300, 1'b0, 32'h304, 1'b1, 1'b0, 32'h0);
      #1;
      check_eq("ok_mispred", 32'(MispredE), 0);
      check_eq("ok_cpc", CorrectPCE, 32'h304);
      tick();
      ex_idle();
      #1;
      check_cnts("ok", 4, 4);

      // Stalled mispredicted branch: no effect until the stall drops.
      ex_drive(32'h100, 1'b0, 32'h104, 1'b1, 1'b1, 32'h60);
      StallE = 1'b1;
      #1;
      check_eq("st_mispred", 32'(MispredE), 0);
      tick();
      check_eq("st_btbf", 32'(BTBF), 0);
      check_cnts("st", 4, 4);
      StallE = 1'b0;
      #1;
      check_eq("ust_mispred", 32'(MispredE), 1);
      check_eq("ust_cpc", CorrectPCE, 32'h60);
      tick();
      ex_idle();
      #1;
      check_eq("ust_btbf", 32'(BTBF), 1);
      check_eq("ust_ppcf", PPCF, 32'h60);
      check_cnts("ust", 5, 5);

      // Same-cycle update and lookup at index 5.
      ex_drive(32'h14, 1'b0, 32'h18, 1'b1, 1'b1, 32'hA0);
      tick();
      ex_idle();
      PCF = 32'h14;
      ex_drive(32'h14, 1'b1, 32'hA0, 1'b1, 1'b1, 32'hB0);
      #1;
      check_eq("sc_old_ppcf", PPCF, 32'hA0);
      check_eq("sc_mispred", 32'(MispredE), 1);
      tick();
      ex_idle();
      #1;
      check_eq("sc_new_ppcf", PPCF, 32'hB0);
      check_cnts("sc", 7, 7);

      // Saturation: one more branch and one more misprediction.
      ex_drive(32'h14, 1'b1, 32'hB0, 1'b1, 1'b1, 32'hB0);
      #1;
      check_eq("sat_mispred", 32'(MispredE), 0);
      tick();
      ex_drive(32'h400, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
      #1;
      check_eq("sat_nb_mispred", 32'(MispredE), 1);
      tick();
      ex_idle();
      #1;
      check_cnts("sat", 7, 7);

      // Reset during an update: the table is cleared and the write dropped.
      rst = 1'b1;
      ex_drive(32'h14, 1'b0, 32'h18, 1'b1, 1'b1, 32'hC0);
      tick();
      rst = 1'b0;
      ex_idle();
      #1;
      check_eq("rmid_btbf", 32'(BTBF), 0);
      check_eq("rmid_ppcf", PPCF, 32'h18);
      check_cnts("rmid", 0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
